// File: rtl/serial_sub_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor: request side drives
// start/a/b, the controller returns busy/done/diff/borrow_out.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused over WIDTH clocks,
// LSB first, with the running borrow held in a flip-flop.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last completed op
//   SHIFT | one operand bit per clock through the cell (busy)
//   DONE  | one-cycle done pulse; a held start is accepted on the exit edge
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] diff_q;
    logic             bor;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             step;
    logic             last;

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;
    logic d;
    logic nb;

    // Two cascaded half subtractors; the second absorbs the incoming borrow.
    always_comb begin
        hs1_d = a_sh[0] ^ b_sh[0];
        hs1_b = ~a_sh[0] & b_sh[0];
        d     = hs1_d ^ bor;
        hs2_b = ~hs1_d & bor;
        nb    = hs1_b | hs2_b;
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Back-to-back ops every WIDTH+1 cycles need acceptance here.
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            bor      <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (load) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {d, res_sh[WIDTH-1:1]};
            bor    <= nb;
            cnt    <= cnt + CW'(1);
            // Results are only published on the final bit so partial
            // differences never reach the outputs.
            if (last) begin
                diff_q   <= {d, res_sh[WIDTH-1:1]};
                borrow_q <= nb;
            end
        end
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 and WIDTH=2 instances against a
// cycle-indexed arithmetic model, plus directed operand/timing cases.
module tb_serial_sub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_v [2];
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic [31:0] diff_v [2];
    logic        bor_v [2];

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 8 : 2;
        localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

        serial_sub_ctrl_if #(.WIDTH(W)) bus ();

        serial_sub_ctrl #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.start  = start_v[g];
        assign bus.a      = a_v[g][W-1:0];
        assign bus.b      = b_v[g][W-1:0];
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign diff_v[g]  = 32'(bus.diff);
        assign bor_v[g]   = bus.borrow_out;

        // Model: edge k counts clocks since reset; an op accepted at edge acc
        // is busy after edges acc..acc+W-1 and done after edge acc+W.
        int          k = 0;
        int          acc = -1000;
        int          next_ok = 0;
        logic [31:0] pend_d = 0;
        logic        pend_b = 0;
        logic [31:0] diff_exp = 0;
        logic        bor_exp = 0;
        int          n_ops = 0;
        int          n_done_exp = 0;
        int          n_done = 0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                k        <= 0;
                acc      <= -1000;
                next_ok  <= 0;
                diff_exp <= 0;
                bor_exp  <= 0;
            end else begin
                k <= k + 1;
                if (k + 1 == acc + W) begin
                    diff_exp   <= pend_d;
                    bor_exp    <= pend_b;
                    n_done_exp <= n_done_exp + 1;
                end
                if ((k + 1 >= next_ok) && start_v[g]) begin
                    acc     <= k + 1;
                    next_ok <= k + 1 + W + 1;
                    pend_d  <= ((a_v[g] & MASK) - (b_v[g] & MASK)) & MASK;
                    pend_b  <= ((a_v[g] & MASK) < (b_v[g] & MASK));
                    n_ops   <= n_ops + 1;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("L%0d_busy", g), 32'(busy_v[g]), 32'((k >= acc) && (k < acc + W)));
            check($sformatf("L%0d_done", g), 32'(done_v[g]), 32'(k == acc + W));
            check($sformatf("L%0d_diff", g), diff_v[g], diff_exp);
            check($sformatf("L%0d_borrow", g), 32'(bor_v[g]), 32'(bor_exp));
            if (done_v[g]) n_done <= n_done + 1;
        end
    end

    // Single WIDTH=8 op on lane 0; returns once done is observed (or budget expires).
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_d, input logic exp_b,
                         input logic [31:0] prev_d);
        int  busy_n;
        bit  seen;
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0] = av;
        b_v[0] = bv;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        a_v[0] = $urandom;
        b_v[0] = $urandom;
        busy_n = 0;
        seen = 0;
        for (int j = 0; j < 12 && !seen; j++) begin
            if (busy_v[0]) busy_n++;
            if (j == 4) check("op_diff_held", diff_v[0], prev_d);
            if (done_v[0]) begin
                seen = 1;
                check("op_done_at", j, 8);
                check("op_diff", diff_v[0], exp_d);
                check("op_borrow", 32'(bor_v[0]), 32'(exp_b));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("op_seen_done", 32'(seen), 1);
        check("op_busy_len", busy_n, 8);
    endtask

    initial begin
        int nd;
        int base0;
        int base1;
        int cyc;
        start_v[0] = 0; start_v[1] = 0;
        a_v[0] = 0; a_v[1] = 0;
        b_v[0] = 0; b_v[1] = 0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_v[0]), 0);
        check("rst_done", 32'(done_v[0]), 0);
        check("rst_diff", diff_v[0], 0);
        check("rst_borrow", 32'(bor_v[0]), 0);
        rst_n = 1'b1;

        do_op(200, 55, 145, 1'b0, 0);
        do_op(5, 10, 8'hFB, 1'b1, 145);
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, 8'hFB);
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 8'h01);

        // start held for 30 edges with operands changing every cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0] = $urandom;
        b_v[0] = $urandom;
        nd = 0;
        for (int j = 0; j < 46; j++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                check("b2b_done_at", j, 8 + 9 * nd);
                nd++;
            end
            if (j == 29) start_v[0] = 1'b0;
            a_v[0] = $urandom;
            b_v[0] = $urandom;
        end
        check("b2b_ops", nd, 4);

        // asynchronous reset in the middle of an op
        @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0] = 32'h33;
        b_v[0] = 32'h11;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_v[0]), 0);
        check("arst_done", 32'(done_v[0]), 0);
        check("arst_diff", diff_v[0], 0);
        check("arst_borrow", 32'(bor_v[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done_v[0]) nd++;
        end
        check("arst_no_done", nd, 0);
        check("arst_diff_after", diff_v[0], 0);
        do_op(1, 2, 8'hFF, 1'b1, 0);

        // random sweep, both widths, including equal and zero-minuend operands
        base0 = lane[0].n_ops;
        base1 = lane[1].n_ops;
        cyc = 0;
        while ((lane[0].n_ops < base0 + 1000 || lane[1].n_ops < base1 + 1000) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                int mode;
                mode = $urandom_range(7);
                a_v[g] = $urandom;
                b_v[g] = $urandom;
                if (mode == 0) b_v[g] = a_v[g];
                if (mode == 1) a_v[g] = 0;
            end
            start_v[0] = (lane[0].n_ops < base0 + 1000) && ($urandom_range(3) != 0);
            start_v[1] = (lane[1].n_ops < base1 + 1000) && ($urandom_range(3) != 0);
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        check("sweep_ops_l0", 32'(lane[0].n_ops >= base0 + 1000), 1);
        check("sweep_ops_l1", 32'(lane[1].n_ops >= base1 + 1000), 1);
        repeat (14) @(negedge clk);
        check("done_count_l0", lane[0].n_done, lane[0].n_done_exp);
        check("done_count_l1", lane[1].n_done, lane[1].n_done_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
